// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 subroutine controller.
// Holds the stack-op encoding, opcode constants and controller states.
// No logic; imported by the controller.
package chip8_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    STK_NONE = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10
  } stk_op_t;

  localparam logic [3:0]  OP_CALL_NIBBLE = 4'h2;
  localparam logic [15:0] OP_RET         = 16'h00EE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_CAPTURE,
    S_FINISH
  } sub_state_t;

endpackage

// File: rtl/chip8_subroutine_ctrl.sv
// Executes CHIP-8 CALL (2NNN) and RET (00EE) against an external stack.
// Latency start->done: CALL 2, RET 3, error/other opcode 1 cycle.
// No backpressure: start is ignored while busy; the stack is assumed always ready.
module chip8_subroutine_ctrl
  import chip8_pkg::*;
#(
  parameter int DEPTH_P  = DEPTH,
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  localparam int DEPTH_W = $clog2(DEPTH_P + 1)
) (
  input  logic                cpu_clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [15:0]         opcode,
  input  logic [ADDR_W_P-1:0] pc,
  output logic [1:0]          stk_we,
  output logic [DATA_W_P-1:0] stk_writedata,
  input  logic [DATA_W_P-1:0] stk_outdata,
  output logic                pc_load,
  output logic [ADDR_W_P-1:0] pc_next,
  output logic                done,
  output logic                busy,
  output logic                err_overflow,
  output logic                err_underflow,
  output logic [DEPTH_W-1:0]  depth
);

  sub_state_t          state;
  logic [ADDR_W_P-1:0] target;   // jump target for CALL, popped address for RET
  logic [ADDR_W_P-1:0] ret_pc;   // return address to push (pc+2, wraps)
  logic                load_q;
  logic                ovf_q;
  logic                unf_q;

  // State machine: decode on start, track depth, latch addresses and result flags
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      depth  <= '0;
      target <= '0;
      ret_pc <= '0;
      load_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            load_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            if (opcode[15:12] == OP_CALL_NIBBLE) begin
              if (depth < DEPTH_W'(DEPTH_P)) begin
                target <= opcode[ADDR_W_P-1:0];
                ret_pc <= pc + ADDR_W_P'(2);
                state  <= S_PUSH;
              end else begin
                ovf_q <= 1'b1;
                state <= S_FINISH;
              end
            end else if (opcode == OP_RET) begin
              if (depth != '0) begin
                state <= S_POP;
              end else begin
                unf_q <= 1'b1;
                state <= S_FINISH;
              end
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_PUSH: begin
          depth  <= depth + DEPTH_W'(1);
          load_q <= 1'b1;
          state  <= S_FINISH;
        end
        S_POP: begin
          depth <= depth - DEPTH_W'(1);
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Only the address bits of the stack word are meaningful
          target <= stk_outdata[ADDR_W_P-1:0];
          load_q <= 1'b1;
          state  <= S_FINISH;
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state and latched flags; all zero in IDLE and under reset
  always_comb begin
    stk_we        = STK_NONE;
    stk_writedata = '0;
    pc_load       = 1'b0;
    pc_next       = '0;
    done          = 1'b0;
    err_overflow  = 1'b0;
    err_underflow = 1'b0;
    busy          = (state != S_IDLE);
    case (state)
      S_PUSH: begin
        stk_we        = STK_PUSH;
        stk_writedata = {{(DATA_W_P-ADDR_W_P){1'b0}}, ret_pc};
      end
      S_POP: begin
        stk_we = STK_POP;
      end
      S_FINISH: begin
        done          = 1'b1;
        pc_load       = load_q;
        pc_next       = load_q ? target : '0;
        err_overflow  = ovf_q;
        err_underflow = unf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_subroutine_ctrl.sv
// Directed bench for chip8_subroutine_ctrl with a behavioural CHIP-8 stack.
`timescale 1ns/1ps
module tb_chip8_subroutine_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] opcode;
  logic [11:0] pc;
  logic [1:0]  stk_we;
  logic [15:0] stk_writedata;
  logic [15:0] stk_outdata;
  logic        pc_load;
  logic [11:0] pc_next;
  logic        done;
  logic        busy;
  logic        err_overflow;
  logic        err_underflow;
  logic [4:0]  depth;

  int checks   = 0;
  int failures = 0;

  always #5 cpu_clk = ~cpu_clk;

  chip8_subroutine_ctrl dut (
    .cpu_clk      (cpu_clk),
    .reset_n      (reset_n),
    .start        (start),
    .opcode       (opcode),
    .pc           (pc),
    .stk_we       (stk_we),
    .stk_writedata(stk_writedata),
    .stk_outdata  (stk_outdata),
    .pc_load      (pc_load),
    .pc_next      (pc_next),
    .done         (done),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .depth        (depth)
  );

  // Behavioural stack: top word registered on the pop edge.
  // Upper nibble of outdata is junk so the controller must ignore it.
  logic [15:0] mem [16];
  logic [4:0]  sp;
  always @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      sp          <= '0;
      stk_outdata <= 16'h0000;
    end else if (stk_we == 2'b01) begin
      mem[sp[3:0]] <= stk_writedata;
      sp           <= sp + 5'd1;
    end else if (stk_we == 2'b10) begin
      stk_outdata <= {4'hA, mem[sp[3:0] - 4'd1][11:0]};
      sp          <= sp - 5'd1;
    end
  end

  int          push_cnt = 0;
  int          pop_cnt  = 0;
  int          bad_we   = 0;
  logic [15:0] last_push = 16'hFFFF;
  always @(posedge cpu_clk) begin
    if (reset_n && stk_we == 2'b01) begin
      push_cnt  <= push_cnt + 1;
      last_push <= stk_writedata;
    end
    if (reset_n && stk_we == 2'b10) pop_cnt <= pop_cnt + 1;
    if (stk_we == 2'b11) bad_we <= bad_we + 1;
  end

  // Results of the most recent run()
  int          r_lat;
  logic        r_load, r_ovf, r_unf, r_busy0;
  logic [11:0] r_next;

  // Issue one instruction and wait (bounded) for done; capture outputs at done.
  task automatic run(input logic [15:0] op, input logic [11:0] p);
    int  n;
    bit  got;
    @(negedge cpu_clk);
    opcode = op; pc = p; start = 1'b1;
    @(posedge cpu_clk);
    #1 start = 1'b0;
    n = 0; got = 0; r_lat = 0;
    r_load = 0; r_ovf = 0; r_unf = 0; r_next = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge cpu_clk);
      if (i == 0) r_busy0 = busy;
      if (done) begin
        got = 1; r_lat = n + 1;
        r_load = pc_load; r_next = pc_next;
        r_ovf = err_overflow; r_unf = err_underflow;
      end else begin
        @(posedge cpu_clk);
        n++;
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL run_timeout: op=%h no done within 20 cycles", op);
    end
  endtask

  task automatic test_reset();
    checks++; if (stk_we !== 2'b00) begin failures++; $display("FAIL reset_stk_we: got %b want 00", stk_we); end
    checks++; if (stk_writedata !== 16'h0) begin failures++; $display("FAIL reset_wdata: got %h want 0000", stk_writedata); end
    checks++; if ({pc_load, done, busy, err_overflow, err_underflow} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b want 00000", {pc_load, done, busy, err_overflow, err_underflow}); end
    checks++; if (pc_next !== 12'h0) begin failures++; $display("FAIL reset_pc_next: got %h want 000", pc_next); end
    checks++; if (depth !== 5'd0) begin failures++; $display("FAIL reset_depth: got %0d want 0", depth); end
  endtask

  task automatic test_call();
    int p0 = push_cnt;
    run(16'h2345, 12'h200);
    checks++; if (r_busy0 !== 1'b1) begin failures++; $display("FAIL call_busy: got %b want 1", r_busy0); end
    checks++; if (r_lat != 2) begin failures++; $display("FAIL call_latency: got %0d want 2", r_lat); end
    checks++; if (push_cnt - p0 != 1) begin failures++; $display("FAIL call_push_count: got %0d want 1", push_cnt - p0); end
    checks++; if (last_push !== 16'h0202) begin failures++; $display("FAIL call_push_data: got %h want 0202", last_push); end
    checks++; if (r_load !== 1'b1 || r_next !== 12'h345) begin failures++; $display("FAIL call_pc: got load=%b next=%h want load=1 next=345", r_load, r_next); end
    checks++; if (r_ovf !== 1'b0 || r_unf !== 1'b0) begin failures++; $display("FAIL call_err: got %b%b want 00", r_ovf, r_unf); end
    checks++; if (depth !== 5'd1) begin failures++; $display("FAIL call_depth: got %0d want 1", depth); end
  endtask

  task automatic test_ret();
    int q0 = pop_cnt;
    run(16'h00EE, 12'h345);
    checks++; if (r_lat != 3) begin failures++; $display("FAIL ret_latency: got %0d want 3", r_lat); end
    checks++; if (pop_cnt - q0 != 1) begin failures++; $display("FAIL ret_pop_count: got %0d want 1", pop_cnt - q0); end
    checks++; if (r_load !== 1'b1 || r_next !== 12'h202) begin failures++; $display("FAIL ret_pc: got load=%b next=%h want load=1 next=202", r_load, r_next); end
    checks++; if (depth !== 5'd0) begin failures++; $display("FAIL ret_depth: got %0d want 0", depth); end
  endtask

  task automatic test_nesting();
    logic [11:0] exp_ret [3] = '{12'h402, 12'h302, 12'h202};
    run(16'h2300, 12'h200);
    run(16'h2400, 12'h300);
    run(16'h2500, 12'h400);
    checks++; if (depth !== 5'd3) begin failures++; $display("FAIL nest_depth: got %0d want 3", depth); end
    for (int i = 0; i < 3; i++) begin
      run(16'h00EE, 12'h000);
      checks++; if (r_next !== exp_ret[i]) begin failures++; $display("FAIL nest_ret%0d: got %h want %h", i, r_next, exp_ret[i]); end
    end
  endtask

  task automatic test_limits();
    int p0;
    int q0;
    for (int i = 0; i < 16; i++) run(16'h2800 | 16'(i), 12'(i * 16));
    checks++; if (depth !== 5'd16) begin failures++; $display("FAIL full_depth: got %0d want 16", depth); end
    p0 = push_cnt;
    run(16'h2999, 12'h500);
    checks++; if (r_ovf !== 1'b1 || r_unf !== 1'b0 || r_load !== 1'b0) begin failures++; $display("FAIL overflow_flags: got ovf=%b unf=%b load=%b want 1 0 0", r_ovf, r_unf, r_load); end
    checks++; if (r_lat != 1) begin failures++; $display("FAIL overflow_latency: got %0d want 1", r_lat); end
    checks++; if (push_cnt != p0 || depth !== 5'd16) begin failures++; $display("FAIL overflow_nostack: got pushes=%0d depth=%0d want 0 16", push_cnt - p0, depth); end
    @(negedge cpu_clk); reset_n = 1'b0;
    @(negedge cpu_clk); reset_n = 1'b1;
    q0 = pop_cnt;
    run(16'h00EE, 12'h000);
    checks++; if (r_unf !== 1'b1 || r_ovf !== 1'b0 || r_load !== 1'b0) begin failures++; $display("FAIL underflow_flags: got unf=%b ovf=%b load=%b want 1 0 0", r_unf, r_ovf, r_load); end
    checks++; if (r_lat != 1 || pop_cnt != q0 || depth !== 5'd0) begin failures++; $display("FAIL underflow_nostack: got lat=%0d pops=%0d depth=%0d want 1 0 0", r_lat, pop_cnt - q0, depth); end
  endtask

  task automatic test_misc();
    int   p0 = push_cnt;
    int   q0 = pop_cnt;
    logic seen_done = 1'b0;
    logic [11:0] seen_next = '0;
    run(16'h1234, 12'h200);
    checks++; if (r_lat != 1 || r_load !== 1'b0 || r_ovf !== 1'b0 || r_unf !== 1'b0) begin failures++; $display("FAIL other_opcode: got lat=%0d load=%b ovf=%b unf=%b want 1 0 0 0", r_lat, r_load, r_ovf, r_unf); end
    checks++; if (push_cnt != p0 || pop_cnt != q0) begin failures++; $display("FAIL other_nostack: got pushes=%0d pops=%0d want 0 0", push_cnt - p0, pop_cnt - q0); end
    // start held high through PUSH with a RET opcode: must be ignored
    @(negedge cpu_clk);
    opcode = 16'h2456; pc = 12'h100; start = 1'b1;
    @(posedge cpu_clk);
    #1 opcode = 16'h00EE;
    @(posedge cpu_clk);
    #1 start = 1'b0;
    @(negedge cpu_clk);
    seen_done = done; seen_next = pc_next;
    repeat (4) @(posedge cpu_clk);
    #1;
    checks++; if (seen_done !== 1'b1 || seen_next !== 12'h456) begin failures++; $display("FAIL busy_start_call: got done=%b next=%h want 1 456", seen_done, seen_next); end
    checks++; if (pop_cnt != q0 || depth !== 5'd1 || busy !== 1'b0) begin failures++; $display("FAIL busy_start_ignored: got pops=%0d depth=%0d busy=%b want 0 1 0", pop_cnt - q0, depth, busy); end
    run(16'h00EE, 12'h456);
    checks++; if (r_next !== 12'h102) begin failures++; $display("FAIL busy_start_ret: got %h want 102", r_next); end
    // Return address wraps past the top of the address space
    run(16'h2ABC, 12'hFFE);
    checks++; if (last_push !== 16'h0000 || r_next !== 12'hABC) begin failures++; $display("FAIL wrap_call: got push=%h next=%h want 0000 abc", last_push, r_next); end
    run(16'h00EE, 12'hABC);
    checks++; if (r_next !== 12'h000) begin failures++; $display("FAIL wrap_ret: got %h want 000", r_next); end
  endtask

  task automatic test_reset_mid_pop();
    run(16'h2777, 12'h600);
    @(negedge cpu_clk);
    opcode = 16'h00EE; start = 1'b1;
    @(posedge cpu_clk);
    #1 start = 1'b0;
    checks++; if (stk_we !== 2'b10) begin failures++; $display("FAIL midpop_in_pop: got %b want 10", stk_we); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (stk_we !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || pc_load !== 1'b0) begin failures++; $display("FAIL midpop_async: got we=%b busy=%b done=%b load=%b want 00 0 0 0", stk_we, busy, done, pc_load); end
    checks++; if (depth !== 5'd0) begin failures++; $display("FAIL midpop_depth: got %0d want 0", depth); end
    @(negedge cpu_clk); reset_n = 1'b1;
    run(16'h00EE, 12'h000);
    checks++; if (r_unf !== 1'b1 || r_load !== 1'b0) begin failures++; $display("FAIL midpop_underflow: got unf=%b load=%b want 1 0", r_unf, r_load); end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    opcode  = 16'h0;
    pc      = 12'h0;
    repeat (2) @(posedge cpu_clk);
    #1 test_reset();
    @(negedge cpu_clk); reset_n = 1'b1;
    test_call();
    test_ret();
    test_nesting();
    test_limits();
    test_misc();
    test_reset_mid_pop();
    checks++; if (bad_we != 0) begin failures++; $display("FAIL stk_we_11: got %0d cycles want 0", bad_we); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
